// File: rtl/conv_pool_engine_if.sv
// conv_pool_engine_if
// Groups the run/busy handshake and every SRAM port of the conv/pool engine.
//   master : the engine (drives busy, all SRAM addresses/enables/data)
//   slave  : the host/memory side (drives run and SRAM read data)
// Handshake: the host raises dut_run while dut_busy is low; the engine samples it
// only in IDLE, raises dut_busy the next cycle and holds it until the terminator
// matrix has been consumed and the last write issued. dut_run is ignored while busy.
// dbg_state mirrors the engine FSM state encoding for observation only.
interface conv_pool_engine_if #(
    parameter int ADDRW = 12,
    parameter int DATAW = 16
);
    logic             dut_run;
    logic             dut_busy;
    logic [ADDRW-1:0] input_sram_read_address;
    logic [DATAW-1:0] input_sram_read_data;
    logic [ADDRW-1:0] weights_sram_read_address;
    logic [DATAW-1:0] weights_sram_read_data;
    logic             output_sram_write_enable;
    logic [ADDRW-1:0] output_sram_write_addresss;
    logic [DATAW-1:0] output_sram_write_data;
    logic             input_sram_write_enable;
    logic [ADDRW-1:0] input_sram_write_address;
    logic [DATAW-1:0] input_sram_write_data;
    logic             weights_sram_write_enable;
    logic [ADDRW-1:0] weights_sram_write_address;
    logic [DATAW-1:0] weights_sram_write_data;
    logic             scratchpad_sram_write_enable;
    logic [ADDRW-1:0] scratchpad_sram_write_address;
    logic [DATAW-1:0] scratchpad_sram_write_data;
    logic [2:0]       dbg_state;

    modport master (
        input  dut_run, input_sram_read_data, weights_sram_read_data,
        output dut_busy, input_sram_read_address, weights_sram_read_address,
        output output_sram_write_enable, output_sram_write_addresss, output_sram_write_data,
        output input_sram_write_enable, input_sram_write_address, input_sram_write_data,
        output weights_sram_write_enable, weights_sram_write_address, weights_sram_write_data,
        output scratchpad_sram_write_enable, scratchpad_sram_write_address,
        output scratchpad_sram_write_data, dbg_state
    );

    modport slave (
        output dut_run, input_sram_read_data, weights_sram_read_data,
        input  dut_busy, input_sram_read_address, weights_sram_read_address,
        input  output_sram_write_enable, output_sram_write_addresss, output_sram_write_data,
        input  input_sram_write_enable, input_sram_write_address, input_sram_write_data,
        input  weights_sram_write_enable, weights_sram_write_address, weights_sram_write_data,
        input  scratchpad_sram_write_enable, scratchpad_sram_write_address,
        input  scratchpad_sram_write_data, dbg_state
    );
endinterface

// File: rtl/conv_pool_engine.sv
// conv_pool_engine
// Streams square signed matrices from the input SRAM until the 16'h00FF terminator.
// Each matrix is convolved with a KSIZE x KSIZE kernel (loaded once from the
// weights SRAM), 2x2 max-pooled, clamped to 0..127 and written two results per word.
// Ports:
//   clk     : rising-edge clock
//   reset_b : asynchronous active-low reset
//   bus     : conv_pool_engine_if.master (run/busy, SRAM ports, debug state)
// Pipeline: tap address (cycle t) -> read data + MAC (t+1) -> pool result
// registered -> ReLU/pack/write registered. FLUSH waits for this to empty.
module conv_pool_engine #(
    parameter int ADDRW = 12,
    parameter int DATAW = 16,
    parameter int PIXW  = 8,
    parameter int KSIZE = 3,
    parameter int ACCW  = 20,
    parameter int MAXN  = 64
) (
    input logic clk,
    input logic reset_b,
    conv_pool_engine_if.master bus
);
    localparam int CW     = $clog2(MAXN + 1);
    localparam int KK     = KSIZE * KSIZE;
    localparam int NWORDS = (KK + 1) / 2;
    localparam int TW     = $clog2(KK);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] K_C   = CW'(KSIZE);
    localparam logic [CW-1:0] K_M1  = CW'(KSIZE - 1);
    localparam logic [CW-1:0] NW_M1 = CW'(NWORDS - 1);
    localparam logic signed [ACCW-1:0] RELU_MAX = ACCW'(127);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_SIZE_RD, S_SIZE_CHK, S_CONV, S_FLUSH, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic [ADDRW-1:0]  r_base;
    logic [CW-1:0]     r_widx, r_wc_idx;
    logic              r_wc_v;
    logic [CW-1:0]     r_n, r_p, r_kr, r_kc, r_pr, r_pc;
    logic [1:0]        r_q, r_fl;
    logic              r_p1_v, r_p1_first, r_p1_last, r_p1_hi;
    logic [1:0]        r_p1_q;
    logic [TW-1:0]     r_p1_tap;
    logic signed [PIXW-1:0] r_w [KK];
    logic signed [ACCW-1:0] r_acc, r_max, r_pool;
    logic              r_pool_v, r_half, r_we;
    logic [PIXW-1:0]   r_hi;
    logic [ADDRW-1:0]  r_waddr, r_oaddr;
    logic [DATAW-1:0]  r_wdata;

    logic [CW-1:0]     w_row, w_col, w_n_new, w_p_new;
    logic [2*CW-1:0]   w_lin, w_nsq;
    logic [ADDRW-1:0]  w_pix_addr, w_next_base;
    logic [TW-1:0]     w_tap;
    logic              w_first_tap, w_last_tap, w_term, w_start, w_pad;
    logic signed [PIXW-1:0]   w_pix, w_wt;
    logic signed [2*PIXW-1:0] w_prod;
    logic signed [ACCW-1:0]   w_prod_ext, w_acc_next, w_max_next;
    logic [PIXW-1:0]   w_relu;

    // Pixel coordinate of the tap currently being addressed.
    assign w_row       = (r_pr << 1) + {{(CW-1){1'b0}}, r_q[1]} + r_kr;
    assign w_col       = (r_pc << 1) + {{(CW-1){1'b0}}, r_q[0]} + r_kc;
    assign w_lin       = {{CW{1'b0}}, w_row} * {{CW{1'b0}}, r_n} + {{CW{1'b0}}, w_col};
    assign w_pix_addr  = r_base + ADDRW'(1) + ADDRW'(w_lin >> 1);
    assign w_nsq       = {{CW{1'b0}}, r_n} * {{CW{1'b0}}, r_n};
    assign w_next_base = r_base + ADDRW'(1) + ADDRW'(w_nsq >> 1);
    assign w_tap       = TW'(r_kr * K_C + r_kc);
    assign w_first_tap = (r_kr == '0) && (r_kc == '0);
    assign w_last_tap  = (r_kr == K_M1) && (r_kc == K_M1);

    assign w_term  = (bus.input_sram_read_data == DATAW'(16'h00FF));
    assign w_n_new = bus.input_sram_read_data[CW-1:0];
    // Conv edge is N-K+1; an odd last conv row/column is dropped by the >>1.
    assign w_p_new = (w_n_new >= K_C + ONE_C) ? ((w_n_new - K_M1) >> 1) : '0;
    assign w_start = (r_state == S_IDLE) && bus.dut_run;
    assign w_pad   = (r_state == S_FLUSH) && (r_fl == 2'd2) && r_half;

    assign w_pix      = r_p1_hi ? bus.input_sram_read_data[2*PIXW-1:PIXW]
                                : bus.input_sram_read_data[PIXW-1:0];
    assign w_wt       = r_w[r_p1_tap];
    assign w_prod     = w_pix * w_wt;
    assign w_prod_ext = {{(ACCW-2*PIXW){w_prod[2*PIXW-1]}}, w_prod};
    assign w_acc_next = r_p1_first ? w_prod_ext : r_acc + w_prod_ext;
    assign w_max_next = (r_p1_q == 2'd0 || w_acc_next > r_max) ? w_acc_next : r_max;
    assign w_relu     = r_pool[ACCW-1] ? '0 :
                        (r_pool > RELU_MAX) ? {1'b0, {(PIXW-1){1'b1}}} :
                        {1'b0, r_pool[PIXW-2:0]};

    assign bus.dut_busy                   = r_busy;
    assign bus.input_sram_read_address    = (r_state == S_SIZE_RD) ? r_base :
                                            (r_state == S_CONV) ? w_pix_addr : '0;
    assign bus.weights_sram_read_address  = (r_state == S_WLOAD) ? ADDRW'(r_widx) : '0;
    assign bus.output_sram_write_enable   = r_we;
    assign bus.output_sram_write_addresss = r_waddr;
    assign bus.output_sram_write_data     = r_wdata;
    assign bus.input_sram_write_enable       = 1'b0;
    assign bus.input_sram_write_address      = '0;
    assign bus.input_sram_write_data         = '0;
    assign bus.weights_sram_write_enable     = 1'b0;
    assign bus.weights_sram_write_address    = '0;
    assign bus.weights_sram_write_data       = '0;
    assign bus.scratchpad_sram_write_enable  = 1'b0;
    assign bus.scratchpad_sram_write_address = '0;
    assign bus.scratchpad_sram_write_data    = '0;
    assign bus.dbg_state                     = r_state;

    // Sequencer: state, loop counters and the tap-tag pipeline register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;  r_busy <= 1'b0;   r_base <= '0;
            r_widx <= '0;       r_wc_idx <= '0;   r_wc_v <= 1'b0;
            r_n <= '0;  r_p <= '0;  r_kr <= '0;  r_kc <= '0;  r_pr <= '0;  r_pc <= '0;
            r_q <= '0;  r_fl <= '0;
            r_p1_v <= 1'b0;  r_p1_first <= 1'b0;  r_p1_last <= 1'b0;  r_p1_hi <= 1'b0;
            r_p1_q <= '0;    r_p1_tap <= '0;
        end else begin
            r_wc_v <= 1'b0;
            r_p1_v <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.dut_run) begin
                        r_state <= S_WLOAD;
                        r_busy  <= 1'b1;
                        r_base  <= '0;
                        r_widx  <= '0;
                    end
                end
                S_WLOAD: begin
                    r_wc_v   <= 1'b1;
                    r_wc_idx <= r_widx;
                    r_widx   <= r_widx + ONE_C;
                    if (r_widx == NW_M1) r_state <= S_SIZE_RD;
                end
                S_SIZE_RD: r_state <= S_SIZE_CHK;
                S_SIZE_CHK: begin
                    if (w_term) begin
                        r_state <= S_DONE;
                    end else begin
                        r_n  <= w_n_new;  r_p  <= w_p_new;
                        r_kr <= '0;  r_kc <= '0;  r_pr <= '0;  r_pc <= '0;
                        r_q  <= '0;  r_fl <= '0;
                        r_state <= (w_p_new == '0) ? S_FLUSH : S_CONV;
                    end
                end
                S_CONV: begin
                    r_p1_v     <= 1'b1;
                    r_p1_first <= w_first_tap;
                    r_p1_last  <= w_last_tap;
                    r_p1_q     <= r_q;
                    r_p1_hi    <= ~w_col[0];
                    r_p1_tap   <= w_tap;
                    if (r_kc != K_M1) begin
                        r_kc <= r_kc + ONE_C;
                    end else begin
                        r_kc <= '0;
                        if (r_kr != K_M1) begin
                            r_kr <= r_kr + ONE_C;
                        end else begin
                            r_kr <= '0;
                            r_q  <= r_q + 2'd1;
                            if (r_q == 2'd3) begin
                                if (r_pc != r_p - ONE_C) begin
                                    r_pc <= r_pc + ONE_C;
                                end else begin
                                    r_pc <= '0;
                                    if (r_pr != r_p - ONE_C) begin
                                        r_pr <= r_pr + ONE_C;
                                    end else begin
                                        r_pr    <= '0;
                                        r_fl    <= '0;
                                        r_state <= S_FLUSH;
                                    end
                                end
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // fl==2: MAC and pool stages are empty, pair buffer is final.
                    r_fl <= r_fl + 2'd1;
                    if (r_fl == 2'd2) begin
                        r_base  <= w_next_base;
                        r_state <= S_SIZE_RD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: weight capture, MAC, pooling, ReLU, pair packing and write-back.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < KK; i++) r_w[i] <= '0;
            r_acc <= '0;  r_max <= '0;  r_pool <= '0;  r_pool_v <= 1'b0;
            r_half <= 1'b0;  r_hi <= '0;  r_we <= 1'b0;
            r_waddr <= '0;  r_wdata <= '0;  r_oaddr <= '0;
        end else begin
            r_we     <= 1'b0;
            r_pool_v <= 1'b0;
            if (r_wc_v) begin
                for (int t = 0; t < KK; t++) begin
                    if ((t / 2) == int'(r_wc_idx))
                        r_w[t] <= (t % 2 == 0) ? bus.weights_sram_read_data[2*PIXW-1:PIXW]
                                               : bus.weights_sram_read_data[PIXW-1:0];
                end
            end
            if (w_start) begin
                r_oaddr <= '0;
                r_half  <= 1'b0;
            end
            if (r_p1_v) begin
                r_acc <= w_acc_next;
                if (r_p1_last) begin
                    r_max <= w_max_next;
                    if (r_p1_q == 2'd3) begin
                        r_pool   <= w_max_next;
                        r_pool_v <= 1'b1;
                    end
                end
            end
            if (r_pool_v) begin
                if (!r_half) begin
                    r_hi   <= w_relu;
                    r_half <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_waddr <= r_oaddr;
                    r_wdata <= DATAW'({r_hi, w_relu});
                    r_oaddr <= r_oaddr + ADDRW'(1);
                    r_half  <= 1'b0;
                end
            end else if (w_pad) begin
                r_we    <= 1'b1;
                r_waddr <= r_oaddr;
                r_wdata <= DATAW'({r_hi, {PIXW{1'b0}}});
                r_oaddr <= r_oaddr + ADDRW'(1);
                r_half  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_pool_engine.sv
module tb_conv_pool_engine;
  localparam int ADDRW = 12;
  localparam int DATAW = 16;
  localparam int K     = 3;

  logic clk;
  logic reset_b;
  int   checks = 0;
  int   errors = 0;
  logic [ADDRW+DATAW-1:0] exp_q[$];
  logic [15:0] in_mem [4096];
  logic [15:0] wt_mem [16];
  logic signed [7:0] wts [K*K];
  int   tb_base;

  conv_pool_engine_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  conv_pool_engine #(.ADDRW(ADDRW), .DATAW(DATAW), .PIXW(8), .KSIZE(K), .ACCW(20), .MAXN(64))
    dut (.clk(clk), .reset_b(reset_b), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // SRAM models, 1-cycle read latency
  always @(posedge clk) begin
    bus.input_sram_read_data   <= in_mem[bus.input_sram_read_address];
    bus.weights_sram_read_data <= wt_mem[bus.weights_sram_read_address[3:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every DUT write must match the head of exp_q
  always @(negedge clk) begin
    logic [ADDRW+DATAW-1:0] e;
    if (bus.output_sram_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_val("write_addr", bus.output_sram_write_addresss, e[27:16]);
        check_val("write_data", bus.output_sram_write_data, e[15:0]);
      end
    end
  end

  // driver / model helpers
  task automatic push_exp(input int addr, input logic [15:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic set_weights();
    for (int i = 0; i < 16; i++) wt_mem[i] = 16'h0000;
    for (int t = 0; t < K*K; t++) begin
      if (t % 2 == 0) wt_mem[t/2][15:8] = wts[t];
      else            wt_mem[t/2][7:0]  = wts[t];
    end
  endtask

  task automatic fill_weights(input int mode, input logic [7:0] val);
    for (int t = 0; t < K*K; t++)
      wts[t] = (mode == 1) ? 8'($urandom_range(0, 255)) : val;
    set_weights();
  endtask

  task automatic put_pix(input int base, input int n, input int r, input int c, input logic [7:0] v);
    int a;
    a = base + 1 + ((r*n + c) >> 1);
    if (c % 2 == 0) in_mem[a][15:8] = v;
    else            in_mem[a][7:0]  = v;
  endtask

  // mode 0: constant fill, 1: random 0..40, 2: random signed byte
  task automatic add_matrix(input int n, input int mode, input logic [7:0] fill);
    logic [7:0] v;
    in_mem[tb_base] = 16'(n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        v = (mode == 0) ? fill : (mode == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        put_pix(tb_base, n, r, c, v);
      end
    tb_base += 1 + n*n/2;
  endtask

  task automatic add_term();
    in_mem[tb_base] = 16'h00FF;
  endtask

  function automatic int get_pix(input int base, input int n, input int r, input int c);
    logic [15:0] w;
    logic signed [7:0] p;
    w = in_mem[base + 1 + ((r*n + c) >> 1)];
    p = (c % 2 == 0) ? w[15:8] : w[7:0];
    return int'(p);
  endfunction

  function automatic logic [7:0] relu(input int v);
    if (v < 0) return 8'd0;
    if (v > 127) return 8'd127;
    return v[7:0];
  endfunction

  // reference model: walk the input image until the terminator
  task automatic model_all();
    int base, oaddr, n, p, m, acc, rr, cc;
    logic half;
    logic [7:0] hi, res;
    base = 0; oaddr = 0; half = 1'b0; hi = 8'd0;
    while (in_mem[base] != 16'h00FF && base < 4000) begin
      n = int'(in_mem[base][7:0]);
      p = (n >= K + 1) ? (n - K + 1) / 2 : 0;
      for (int pr = 0; pr < p; pr++)
        for (int pc = 0; pc < p; pc++) begin
          m = -(1 << 30);
          for (int q = 0; q < 4; q++) begin
            rr = 2*pr + q/2;
            cc = 2*pc + q%2;
            acc = 0;
            for (int kr = 0; kr < K; kr++)
              for (int kc = 0; kc < K; kc++)
                acc += get_pix(base, n, rr + kr, cc + kc) * int'(wts[kr*K + kc]);
            if (acc > m) m = acc;
          end
          res = relu(m);
          if (!half) begin hi = res; half = 1'b1; end
          else begin push_exp(oaddr, {hi, res}); oaddr++; half = 1'b0; end
        end
      if (half) begin push_exp(oaddr, {hi, 8'h00}); oaddr++; half = 1'b0; end
      base += 1 + n*n/2;
    end
  endtask

  task automatic run_engine(input string tag, input int budget, output int busy_cycles);
    int cyc;
    @(negedge clk) bus.dut_run = 1'b1;
    @(negedge clk);
    check_val({tag, "_busy_rise"}, bus.dut_busy, 1);
    cyc = 1;
    @(negedge clk);
    if (bus.dut_busy) cyc++;
    @(negedge clk) bus.dut_run = 1'b0;  // held high while busy: must be ignored
    if (bus.dut_busy) cyc++;
    while (bus.dut_busy && cyc < budget) begin
      @(negedge clk);
      if (bus.dut_busy) cyc++;
    end
    check_val({tag, "_idle"}, bus.dut_busy, 0);
    repeat (3) @(negedge clk);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    busy_cycles = cyc;
  endtask

  initial begin
    int bc, n1, n2;
    bus.dut_run = 1'b0;
    bus.input_sram_read_data = '0;
    bus.weights_sram_read_data = '0;
    for (int i = 0; i < 4096; i++) in_mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) wt_mem[i] = 16'h0000;
    reset_b = 1'b1;
    #2 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.dut_busy, 0);
    check_val("rst_we", bus.output_sram_write_enable, 0);
    check_val("rst_waddr", bus.output_sram_write_addresss, 0);
    check_val("rst_wdata", bus.output_sram_write_data, 0);
    check_val("rst_in_addr", bus.input_sram_read_address, 0);
    check_val("rst_wt_addr", bus.weights_sram_read_address, 0);
    check_val("tied_in_we", bus.input_sram_write_enable, 0);
    check_val("tied_wt_we", bus.weights_sram_write_enable, 0);
    check_val("tied_sp_we", bus.scratchpad_sram_write_enable, 0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // N=4 ones, weights 1
    fill_weights(0, 8'd1);
    tb_base = 0; add_matrix(4, 0, 8'd1); add_term();
    push_exp(0, 16'h0900);
    run_engine("ones4", 2000, bc);

    // terminator only
    tb_base = 0; add_term();
    run_engine("term_only", 200, bc);
    check_val("term_busy_ge3", bc >= 3, 1);

    // N=8, saturating positives
    fill_weights(0, 8'd127);
    tb_base = 0; add_matrix(8, 0, 8'd127); add_term();
    for (int i = 0; i < 4; i++) push_exp(i, 16'h7F7F);
    push_exp(4, 16'h7F00);
    run_engine("sat8", 3000, bc);

    // N=6, negative weights -> clamped to zero
    fill_weights(0, 8'hFF);
    tb_base = 0; add_matrix(6, 0, 8'd5); add_term();
    push_exp(0, 16'h0000);
    push_exp(1, 16'h0000);
    run_engine("neg6", 3000, bc);

    // mixed-sign pool window: -5,-2,3,1 -> 3
    fill_weights(0, 8'd0);
    wts[0] = 8'sd1; set_weights();
    tb_base = 0; add_matrix(4, 0, 8'd0); add_term();
    put_pix(0, 4, 0, 0, 8'hFB); put_pix(0, 4, 0, 1, 8'hFE);
    put_pix(0, 4, 1, 0, 8'h03); put_pix(0, 4, 1, 1, 8'h01);
    push_exp(0, 16'h0300);
    run_engine("mixed", 2000, bc);

    // back-to-back N=4 then N=6; terminator at 9+1+18=28
    fill_weights(0, 8'd1);
    tb_base = 0; add_matrix(4, 0, 8'd1); add_matrix(6, 0, 8'd1); add_term();
    push_exp(0, 16'h0900); push_exp(1, 16'h0909); push_exp(2, 16'h0909);
    run_engine("two_mats", 4000, bc);

    // N=2 (no output) then random N=4
    fill_weights(1, 8'd0);
    tb_base = 0; add_matrix(2, 2, 8'd0); add_matrix(4, 2, 8'd0); add_term();
    model_all();
    run_engine("small_then4", 3000, bc);

    // random matrices against the model
    for (int it = 0; it < 3; it++) begin
      fill_weights(1, 8'd0);
      n1 = 2 * $urandom_range(2, 5);
      n2 = 2 * $urandom_range(2, 5);
      tb_base = 0; add_matrix(n1, 1 + (it % 2), 8'd0); add_matrix(n2, 2, 8'd0); add_term();
      model_all();
      run_engine("rand", 6000, bc);
    end

    // reset mid-CONV, then re-run to the same golden results
    fill_weights(1, 8'd0);
    tb_base = 0; add_matrix(8, 2, 8'd0); add_term();
    model_all();
    @(negedge clk) bus.dut_run = 1'b1;
    @(negedge clk) bus.dut_run = 1'b0;
    repeat (60) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check_val("midrst_busy", bus.dut_busy, 0);
    check_val("midrst_we", bus.output_sram_write_enable, 0);
    check_val("midrst_waddr", bus.output_sram_write_addresss, 0);
    check_val("midrst_wdata", bus.output_sram_write_data, 0);
    check_val("midrst_in_addr", bus.input_sram_read_address, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    reset_b = 1'b1;
    repeat (20) @(negedge clk);
    check_val("midrst_stays_idle", bus.dut_busy, 0);
    model_all();
    run_engine("rerun", 3000, bc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
